// File: rtl/fp_mul_pkg.sv
// Shared types, flag positions and format helpers for the sequential FP multiplier.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Operand class captured at accept; decides whether the datapath result is used.
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_NAN  = 2'd1,
    SPC_INF  = 2'd2,
    SPC_ZERO = 2'd3
  } spc_t;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic RND_RNE   = 1'b0;
  localparam logic RND_TRUNC = 1'b1;

  function automatic int fp_bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_canon_nan(int exp_w, int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_booth_step.sv
// One radix-4 Booth digit: recode a 3-bit window into 0/+-A/+-2A and accumulate.
module fp_mul_booth_step #(
  parameter int PW = 18
) (
  input  logic [2:0]    win,
  input  logic [PW-1:0] mcand,
  input  logic [PW-1:0] acc_in,
  output logic [PW-1:0] acc_out
);

  logic [PW-1:0] pp;

  // Arithmetic is modulo 2^PW; the final product is non-negative and narrower.
  always_comb begin
    pp = '0;
    unique case (win)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    acc_out = acc_in + pp;
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: iterative Booth multiply, then normalise and round.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready only in IDLE, out_valid only in DONE.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);

  localparam int N       = MAN_W + 1;
  localparam int MUL_CYC = (MAN_W + 3) / 2;
  localparam int MW      = 2 * MUL_CYC;
  localparam int PW      = N + MW;
  localparam int EW      = EXP_W + 2;
  localparam int CW      = $clog2(MUL_CYC + 1);
  localparam logic signed [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_E = '0;
  localparam logic [W-1:0] NAN_WORD = W'(fp_canon_nan(EXP_W, MAN_W));

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   sgn;
  logic signed [EW-1:0]   exp_r;
  spc_t                   spc;
  logic                   rm;
  logic [PW-1:0]          mcand, acc, acc_next;
  logic [MW-1:0]          mplier;
  logic                   prev;

  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  spc_t                   spc_in;
  logic signed [EW-1:0]   exp_in;

  assign ea = in_a[W-2 -: EXP_W];
  assign eb = in_b[W-2 -: EXP_W];
  assign fa = in_a[MAN_W-1:0];
  assign fb = in_b[MAN_W-1:0];

  // Exponent 0 covers both zero and denormal, which are flushed to zero.
  always_comb begin
    nan_a  = (&ea) && (|fa);
    nan_b  = (&eb) && (|fb);
    inf_a  = (&ea) && !(|fa);
    inf_b  = (&eb) && !(|fb);
    zero_a = !(|ea);
    zero_b = !(|eb);
    spc_in = SPC_NONE;
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) spc_in = SPC_NAN;
    else if (inf_a || inf_b)                                       spc_in = SPC_INF;
    else if (zero_a || zero_b)                                     spc_in = SPC_ZERO;
    exp_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
  end

  fp_mul_booth_step #(.PW(PW)) u_step (
    .win     ({mplier[1:0], prev}),
    .mcand   (mcand),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  logic [2*N-1:0]       p, pn;
  logic                 msb, guard, sticky, up;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       fr;
  logic signed [EW-1:0] e2;
  logic [W-1:0]         res_n;
  logic [3:0]           flg_n;

  // Left-align the product so the hidden bit sits at the top of pn either way.
  always_comb begin
    p      = acc[2*N-1:0];
    msb    = p[2*N-1];
    pn     = msb ? p : (p << 1);
    frac   = pn[2*N-2 -: MAN_W];
    guard  = pn[2*N-2-MAN_W];
    sticky = |pn[2*N-3-MAN_W:0];
    up     = (rm == RND_RNE) && guard && (sticky || frac[0]);
    fr     = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    e2     = exp_r + $signed({{(EW-1){1'b0}}, msb}) + $signed({{(EW-1){1'b0}}, fr[MAN_W]});
    res_n  = {sgn, e2[EXP_W-1:0], fr[MAN_W-1:0]};
    flg_n  = '0;
    flg_n[FLAG_NX] = guard || sticky;
    if (e2 >= EMAX_E) begin
      res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_n[FLAG_OF] = 1'b1;
      flg_n[FLAG_NX] = 1'b1;
    end else if (e2 <= ZERO_E) begin
      res_n = {sgn, {(W-1){1'b0}}};
      flg_n[FLAG_UF] = 1'b1;
      flg_n[FLAG_NX] = 1'b1;
    end
    case (spc)
      SPC_NAN: begin
        res_n = NAN_WORD;
        flg_n = '0;
        flg_n[FLAG_NV] = 1'b1;
      end
      SPC_INF: begin
        res_n = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flg_n = '0;
      end
      SPC_ZERO: begin
        res_n = {sgn, {(W-1){1'b0}}};
        flg_n = '0;
      end
      default: ;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{acc[PW-1:2*N], pn[2*N-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      cnt        <= '0;
      sgn        <= 1'b0;
      exp_r      <= '0;
      spc        <= SPC_NONE;
      rm         <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      prev       <= 1'b0;
      acc        <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state    <= S_MUL;
          in_ready <= 1'b0;
          sgn      <= in_a[W-1] ^ in_b[W-1];
          exp_r    <= exp_in;
          spc      <= spc_in;
          rm       <= rnd_mode;
          mcand    <= {{(PW-N){1'b0}}, 1'b1, fa};
          mplier   <= {{(MW-N){1'b0}}, 1'b1, fb};
          prev     <= 1'b0;
          acc      <= '0;
          cnt      <= '0;
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 2;
          mplier <= mplier >> 2;
          prev   <= mplier[1];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(MUL_CYC - 1)) state <= S_NORM;
        end
        S_NORM: begin
          out_result <= res_n;
          out_flags  <= flg_n;
          out_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
